// File: rtl/decode_adc_sequencer.sv
// Prefetch-side sequencer for the ADC decoder: buffers instruction bytes, sizes each
// instruction from opcode/ModR/M and presents one complete instruction per valid/ready handshake.
module decode_adc_sequencer #(
    parameter int WINDOW_BYTES  = 8,
    parameter int OPERAND_BYTES = 2
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_flush,
    input  logic [7:0]                           i_byte,
    input  logic                                 i_byte_valid,
    output logic                                 o_byte_ready,
    output logic                                 o_insn_valid,
    input  logic                                 i_insn_ready,
    output logic [WINDOW_BYTES-1:0][7:0]         o_insn,
    output logic [3:0]                           o_insn_len,
    output logic [2:0]                           o_insn_class,
    output logic                                 o_error,
    output logic                                 o_dbg_state,
    output logic [$clog2(WINDOW_BYTES+1)-1:0]    o_dbg_count
);

    localparam int CW = $clog2(WINDOW_BYTES + 1);

    // Handshakes: a byte moves when i_byte_valid & o_byte_ready; an instruction moves when
    // o_insn_valid & i_insn_ready. Neither ready depends combinationally on the other side's valid.
    typedef enum logic {S_FETCH = 1'b0, S_ISSUE = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [7:0]      win_q [WINDOW_BYTES];
    logic [7:0]      win_d [WINDOW_BYTES];
    logic [CW-1:0]   count_q, count_d;

    logic            cur_complete, nxt_complete;
    logic [3:0]      cur_len, nxt_len;
    logic [2:0]      cur_cls, nxt_cls;
    logic            cur_err, nxt_err;
    logic            accept, pop;

    function automatic void decode_insn(
        input  logic [7:0] op,
        input  logic [7:0] modrm,
        input  int         cnt,
        output logic       complete,
        output logic [3:0] len,
        output logic [2:0] cls,
        output logic       err
    );
        int   disp;
        int   l;
        logic need_b1;
        logic is_reg;
        is_reg  = (modrm[7:6] == 2'b11);
        if (modrm[7:6] == 2'b00 && modrm[2:0] == 3'b110) disp = 2;
        else if (modrm[7:6] == 2'b01)                    disp = 1;
        else if (modrm[7:6] == 2'b10)                    disp = 2;
        else                                             disp = 0;
        l       = 1;
        cls     = 3'd0;
        err     = 1'b0;
        need_b1 = 1'b0;
        case (op)
            8'h10, 8'h11: begin
                need_b1 = 1'b1;
                l       = 2 + disp;
                cls     = is_reg ? 3'd1 : 3'd4;
            end
            8'h12, 8'h13: begin
                need_b1 = 1'b1;
                l       = 2 + disp;
                cls     = is_reg ? 3'd2 : 3'd3;
            end
            8'h14: begin
                l   = 2;
                cls = 3'd6;
            end
            8'h15: begin
                l   = 1 + OPERAND_BYTES;
                cls = 3'd6;
            end
            8'h80, 8'h81, 8'h83: begin
                need_b1 = 1'b1;
                // Group-1 opcodes are ADC only with reg field /2.
                if (modrm[5:3] != 3'b010) begin
                    err = 1'b1;
                end else begin
                    l   = (op == 8'h81) ? (2 + disp + OPERAND_BYTES) : (3 + disp);
                    cls = is_reg ? 3'd5 : 3'd7;
                end
            end
            default: err = 1'b1;
        endcase
        len      = 4'(l);
        complete = (cnt > 0) && (!need_b1 || cnt >= 2) && (cnt >= l);
    endfunction

    // Decode of what is currently held, and of what the buffer will hold after this edge.
    always_comb begin
        decode_insn(win_q[0], win_q[1], int'(count_q), cur_complete, cur_len, cur_cls, cur_err);
        decode_insn(win_d[0], win_d[1], int'(count_d), nxt_complete, nxt_len, nxt_cls, nxt_err);
    end

    always_comb begin
        accept  = i_byte_valid && (int'(count_q) < WINDOW_BYTES);
        pop     = (state_q == S_ISSUE) && i_insn_ready;
        win_d   = win_q;
        count_d = count_q;
        if (i_flush) begin
            for (int i = 0; i < WINDOW_BYTES; i++) win_d[i] = 8'h00;
            count_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < WINDOW_BYTES; i++) begin
                    win_d[i] = 8'h00;
                    for (int j = 0; j < WINDOW_BYTES; j++) begin
                        if (j == i + int'(cur_len)) win_d[i] = win_q[j];
                    end
                end
                count_d = count_q - CW'(cur_len);
            end
            // The incoming byte lands just above whatever survives the pop.
            if (accept) begin
                for (int i = 0; i < WINDOW_BYTES; i++) begin
                    if (i == int'(count_d)) win_d[i] = i_byte;
                end
                count_d = count_d + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
            for (int i = 0; i < WINDOW_BYTES; i++) win_q[i] <= 8'h00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            for (int i = 0; i < WINDOW_BYTES; i++) win_q[i] <= win_d[i];
        end
    end

    always_comb begin
        state_d = S_FETCH;
        if (!i_flush && nxt_complete) state_d = S_ISSUE;
    end

    always_comb begin
        o_insn_valid = (state_q == S_ISSUE);
        o_byte_ready = (int'(count_q) < WINDOW_BYTES);
        o_insn_len   = o_insn_valid ? cur_len : 4'd0;
        o_insn_class = o_insn_valid ? cur_cls : 3'd0;
        o_error      = o_insn_valid ? cur_err : 1'b0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            o_insn[i] = (o_insn_valid && i < int'(cur_len)) ? win_q[i] : 8'h00;
        end
        o_dbg_state  = state_q;
        o_dbg_count  = count_q;
    end

endmodule

// File: tb/tb_decode_adc_sequencer.sv
// Directed bench for decode_adc_sequencer: a 16-bit-operand instance for most cases and a
// 32-bit-operand instance for the 8-byte instruction.
module tb_decode_adc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_reset = 1'b1;
  logic             i_flush = 1'b0;
  logic [7:0]       i_byte = 8'h00;
  logic             i_byte_valid = 1'b0;
  logic             o_byte_ready;
  logic             o_insn_valid;
  logic             i_insn_ready = 1'b0;
  logic [7:0][7:0]  o_insn;
  logic [3:0]       o_insn_len;
  logic [2:0]       o_insn_class;
  logic             o_error;
  logic             o_dbg_state;
  logic [3:0]       o_dbg_count;

  logic [7:0]       b4_byte = 8'h00;
  logic             b4_valid = 1'b0;
  logic             b4_byte_ready;
  logic             b4_insn_valid;
  logic [7:0][7:0]  b4_insn;
  logic [3:0]       b4_len;
  logic [2:0]       b4_class;
  logic             b4_error;
  logic             b4_state;
  logic [3:0]       b4_count;

  decode_adc_sequencer #(.WINDOW_BYTES(8), .OPERAND_BYTES(2)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_flush(i_flush),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
    .o_insn_valid(o_insn_valid), .i_insn_ready(i_insn_ready), .o_insn(o_insn),
    .o_insn_len(o_insn_len), .o_insn_class(o_insn_class), .o_error(o_error),
    .o_dbg_state(o_dbg_state), .o_dbg_count(o_dbg_count)
  );

  decode_adc_sequencer #(.WINDOW_BYTES(8), .OPERAND_BYTES(4)) dut4 (
    .i_clk(clk), .i_reset(i_reset), .i_flush(1'b0),
    .i_byte(b4_byte), .i_byte_valid(b4_valid), .o_byte_ready(b4_byte_ready),
    .o_insn_valid(b4_insn_valid), .i_insn_ready(1'b0), .o_insn(b4_insn),
    .o_insn_len(b4_len), .o_insn_class(b4_class), .o_error(b4_error),
    .o_dbg_state(b4_state), .o_dbg_count(b4_count)
  );

  int checks = 0;
  int failures = 0;
  // {error, class, len} of each instruction expected to be taken by execute
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_byte = b;
    i_byte_valid = 1'b1;
    tick();
    i_byte_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    b4_byte = b;
    b4_valid = 1'b1;
    tick();
    b4_valid = 1'b0;
  endtask

  // Scoreboard: every accepted instruction must match the head of exp_q.
  always @(negedge clk) begin
    if (!i_reset && !i_flush && o_insn_valid && i_insn_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", {o_error, o_insn_class, o_insn_len}, 8'hxx);
      end else begin
        check("issue", {24'h0, o_error, o_insn_class, o_insn_len}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // Reset
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    check("rst_valid", o_insn_valid, 1'b0);
    check("rst_count", o_dbg_count, 4'd0);
    check("rst_ready", o_byte_ready, 1'b1);
    check("rst_class", o_insn_class, 3'd0);
    check("rst_len", o_insn_len, 4'd0);
    check("rst_err", o_error, 1'b0);
    check("rst_insn", o_insn[3:0], 32'h0);
    check("rst_state", o_dbg_state, 1'b0);

    // 11 C8: register-to-register, valid the cycle after the last byte
    i_insn_ready = 1'b1;
    send(8'h11);
    check("t2_not_yet", o_insn_valid, 1'b0);
    send(8'hC8);
    check("t2_valid", o_insn_valid, 1'b1);
    check("t2_len", o_insn_len, 4'd2);
    check("t2_class", o_insn_class, 3'd1);
    check("t2_err", o_error, 1'b0);
    check("t2_bytes", {o_insn[1], o_insn[0]}, 16'hC811);
    check("t2_mask", o_insn[2], 8'h00);
    exp_q.push_back({1'b0, 3'd1, 4'd2});
    tick();
    check("t2_popped_valid", o_insn_valid, 1'b0);
    check("t2_popped_count", o_dbg_count, 4'd0);

    // 81 16 disp16 imm16: imm->mem, 6 bytes
    i_insn_ready = 1'b0;
    send(8'h81); send(8'h16); send(8'h34); send(8'h12); send(8'h78);
    check("t3_not_yet", o_insn_valid, 1'b0);
    send(8'h56);
    check("t3_valid", o_insn_valid, 1'b1);
    check("t3_len", o_insn_len, 4'd6);
    check("t3_class", o_insn_class, 3'd7);
    check("t3_byte5", o_insn[5], 8'h56);
    check("t3_mask6", o_insn[6], 8'h00);
    exp_q.push_back({1'b0, 3'd7, 4'd6});
    i_insn_ready = 1'b1;
    tick();
    i_insn_ready = 1'b0;
    check("t3_count", o_dbg_count, 4'd0);

    // 15 imm16 held, buffer fills to 8, then back-to-back issues
    send(8'h15); send(8'hCD); send(8'hAB);
    check("t4_valid", o_insn_valid, 1'b1);
    check("t4_len", o_insn_len, 4'd3);
    check("t4_class", o_insn_class, 3'd6);
    send(8'h10); send(8'h47); send(8'h05); send(8'h14); send(8'h22);
    check("t4_full_ready", o_byte_ready, 1'b0);
    check("t4_full_count", o_dbg_count, 4'd8);
    send(8'hEE);
    check("t4_no_overflow", o_dbg_count, 4'd8);
    check("t4_held_bytes", {o_insn[2], o_insn[1], o_insn[0]}, 24'hABCD15);
    check("t4_held_len", o_insn_len, 4'd3);
    exp_q.push_back({1'b0, 3'd6, 4'd3});
    exp_q.push_back({1'b0, 3'd4, 4'd3});
    exp_q.push_back({1'b0, 3'd6, 4'd2});
    i_insn_ready = 1'b1;
    tick();
    check("t4_b2b_valid", o_insn_valid, 1'b1);
    check("t4_b2b_len", o_insn_len, 4'd3);
    check("t4_b2b_class", o_insn_class, 3'd4);
    check("t4_b2b_bytes", {o_insn[2], o_insn[1], o_insn[0]}, 24'h054710);
    check("t4_b2b_count", o_dbg_count, 4'd5);
    tick();
    check("t4_third_len", o_insn_len, 4'd2);
    check("t4_third_class", o_insn_class, 3'd6);
    check("t4_third_count", o_dbg_count, 4'd2);
    tick();
    check("t4_drain_valid", o_insn_valid, 1'b0);
    check("t4_drain_count", o_dbg_count, 4'd0);

    // Errors: 0F, then 80 /3 (D8) popped as one byte, D8 and 01 re-decoded as errors
    exp_q.push_back({1'b1, 3'd0, 4'd1});
    exp_q.push_back({1'b1, 3'd0, 4'd1});
    exp_q.push_back({1'b1, 3'd0, 4'd1});
    exp_q.push_back({1'b1, 3'd0, 4'd1});
    send(8'h0F);
    check("t5_0f_err", o_error, 1'b1);
    check("t5_0f_len", o_insn_len, 4'd1);
    check("t5_0f_class", o_insn_class, 3'd0);
    send(8'h80);
    check("t5_80_wait", o_insn_valid, 1'b0);
    check("t5_80_count", o_dbg_count, 4'd1);
    send(8'hD8);
    check("t5_80_err", o_error, 1'b1);
    check("t5_80_bytes", {o_insn[1], o_insn[0]}, 16'h0080);
    check("t5_80_len", o_insn_len, 4'd1);
    i_byte = 8'h01;
    i_byte_valid = 1'b1;
    tick();
    i_byte_valid = 1'b0;
    check("t5_d8_insn", o_insn[0], 8'hD8);
    check("t5_d8_err", o_error, 1'b1);
    check("t5_d8_count", o_dbg_count, 4'd2);
    tick();
    check("t5_01_insn", o_insn[0], 8'h01);
    check("t5_01_count", o_dbg_count, 4'd1);
    tick();
    check("t5_done_valid", o_insn_valid, 1'b0);
    check("t5_done_count", o_dbg_count, 4'd0);
    i_insn_ready = 1'b0;

    // Flush with pending bytes, and flush coincident with a handshake
    send(8'h81); send(8'h16);
    check("t6_pre_count", o_dbg_count, 4'd2);
    i_flush = 1'b1;
    i_byte = 8'h34;
    i_byte_valid = 1'b1;
    tick();
    i_flush = 1'b0;
    i_byte_valid = 1'b0;
    check("t6_flush_count", o_dbg_count, 4'd0);
    check("t6_flush_valid", o_insn_valid, 1'b0);
    check("t6_flush_ready", o_byte_ready, 1'b1);
    send(8'h14); send(8'h55);
    check("t6_pending_valid", o_insn_valid, 1'b1);
    i_insn_ready = 1'b1;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_insn_ready = 1'b0;
    check("t6_hs_flush_count", o_dbg_count, 4'd0);
    check("t6_hs_flush_valid", o_insn_valid, 1'b0);
    check("t6_hs_flush_len", o_insn_len, 4'd0);
    check("t6_hs_flush_state", o_dbg_state, 1'b0);

    // 32-bit operand instance: 81 16 disp16 imm32 -> 8 bytes
    send4(8'h81); send4(8'h16); send4(8'h34); send4(8'h12);
    send4(8'h78); send4(8'h56); send4(8'h9A);
    check("t3w_not_yet", b4_insn_valid, 1'b0);
    send4(8'hBC);
    check("t3w_valid", b4_insn_valid, 1'b1);
    check("t3w_len", b4_len, 4'd8);
    check("t3w_class", b4_class, 3'd7);
    check("t3w_err", b4_error, 1'b0);
    check("t3w_last", b4_insn[7], 8'hBC);
    check("t3w_ready", b4_byte_ready, 1'b0);
    check("t3w_count", b4_count, 4'd8);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
